// File: rtl/cache_pkg.sv
// Shared types and helpers for the L1 refill engine.
//   refill_state_t : miss-handling FSM encoding
//   WORD_BYTES     : bytes per word for the default 32-bit data path
//   line_align()   : clears the in-line byte offset bits of an address
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    FILL    = 3'd4
  } refill_state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BLOCK_SIZE = 4;
  localparam int unsigned WORD_BYTES     = DEF_DATA_WIDTH / 8;

  // Works on a 64-bit container so any ADDR_WIDTH up to 64 can use it;
  // callers cast the result back to their own address width.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned off_bits);
    logic [63:0] mask;
    mask = ~((64'd1 << off_bits) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// One cache line of storage (BLOCK_SIZE words of DATA_WIDTH bits).
//   clk, reset    : clock, synchronous active-high reset (clears contents)
//   load_i        : load the whole line from load_data_i (word0 in LSBs)
//   we_i / widx_i : write wdata_i into word widx_i
//   line_o        : flattened line contents, word0 in LSBs
// A whole-line load takes priority over a single-word write.
module refill_line_buffer
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned IDX_W      = $clog2(BLOCK_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_i,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] load_data_i,
  input  logic                             we_i,
  input  logic [IDX_W-1:0]                 widx_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] line_o
);

  logic [DATA_WIDTH-1:0] mem_q [BLOCK_SIZE];

  // Word storage: reset clear, whole-line load or single-word write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
        mem_q[i] <= '0;
      end
    end else if (load_i) begin
      for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
        mem_q[i] <= load_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Flatten the array, word0 in the LSBs.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
      line_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
  end

endmodule

// File: rtl/l1_refill_engine.sv
// Blocking L1 miss handler on the L2-facing side (one outstanding miss).
//   miss_req_*  : miss from L1, accepted only in IDLE; all fields latched
//   l2_req_*    : write beats for a dirty victim, then one line read request
//   l2_rdata_*  : read beats in ascending word order, no backpressure
//   fill_*      : assembled line returned to L1
//   busy        : engine is not IDLE
module l1_refill_engine
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             miss_req_valid,
  output logic                             miss_req_ready,
  input  logic [ADDR_WIDTH-1:0]            miss_req_addr,
  input  logic                             miss_evict_dirty,
  input  logic [ADDR_WIDTH-1:0]            miss_evict_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] miss_evict_data,
  output logic                             l2_req_valid,
  input  logic                             l2_req_ready,
  output logic                             l2_req_write,
  output logic [ADDR_WIDTH-1:0]            l2_req_addr,
  output logic [DATA_WIDTH-1:0]            l2_wdata,
  input  logic                             l2_rdata_valid,
  input  logic [DATA_WIDTH-1:0]            l2_rdata,
  output logic                             fill_valid,
  input  logic                             fill_ready,
  output logic [ADDR_WIDTH-1:0]            fill_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fill_data,
  output logic                             busy
);

  localparam int unsigned BEAT_W   = $clog2(BLOCK_SIZE);
  localparam int unsigned WORD_B   = DATA_WIDTH / 8;
  localparam int unsigned WORD_SH  = $clog2(WORD_B);
  localparam int unsigned OFF_BITS = $clog2(BLOCK_SIZE * WORD_B);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

  refill_state_t           state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
  logic [ADDR_WIDTH-1:0]   evict_addr_q, evict_addr_d;
  logic                    miss_hs_s;
  logic                    fill_we_s;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] victim_line_s;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] fill_line_s;

  assign miss_hs_s = miss_req_valid & (state_q == IDLE);
  // Beats arriving outside RD_DATA never reach the fill buffer.
  assign fill_we_s = (state_q == RD_DATA) & l2_rdata_valid;

  refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_victim_buf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (miss_hs_s),
    .load_data_i (miss_evict_data),
    .we_i        (1'b0),
    .widx_i      ('0),
    .wdata_i     ('0),
    .line_o      (victim_line_s)
  );

  refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_fill_buf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (1'b0),
    .load_data_i ('0),
    .we_i        (fill_we_s),
    .widx_i      (beat_q),
    .wdata_i     (l2_rdata),
    .line_o      (fill_line_s)
  );

  // State, beat counter and latched miss addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_addr_q  <= '0;
      evict_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_addr_q  <= miss_addr_d;
      evict_addr_q <= evict_addr_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_addr_d  = miss_addr_q;
    evict_addr_d = evict_addr_q;
    case (state_q)
      IDLE: begin
        if (miss_hs_s) begin
          miss_addr_d  = ADDR_WIDTH'(line_align(64'(miss_req_addr), OFF_BITS));
          evict_addr_d = ADDR_WIDTH'(line_align(64'(miss_evict_addr), OFF_BITS));
          state_d      = miss_evict_dirty ? WB_REQ : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WB_REQ: begin
        if (l2_req_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RD_REQ;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      RD_REQ: begin
        if (l2_req_ready) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        if (l2_rdata_valid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = FILL;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      FILL: begin
        if (fill_ready) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they hold while stalled.
  always_comb begin
    miss_req_ready = 1'b0;
    l2_req_valid   = 1'b0;
    l2_req_write   = 1'b0;
    l2_req_addr    = '0;
    l2_wdata       = '0;
    fill_valid     = 1'b0;
    fill_addr      = miss_addr_q;
    fill_data      = fill_line_s;
    busy           = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        miss_req_ready = 1'b1;
      end
      WB_REQ: begin
        l2_req_valid = 1'b1;
        l2_req_write = 1'b1;
        l2_req_addr  = evict_addr_q + (ADDR_WIDTH'(beat_q) << WORD_SH);
        l2_wdata     = victim_line_s[32'(beat_q) * DATA_WIDTH +: DATA_WIDTH];
      end
      RD_REQ: begin
        l2_req_valid = 1'b1;
        l2_req_addr  = miss_addr_q;
      end
      FILL: begin
        fill_valid = 1'b1;
      end
      default: begin
        miss_req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_l1_refill_engine.sv
// Directed-vector bench for l1_refill_engine (default 32/32/4 config).
// Inputs change and outputs are checked on the falling clock edge.
module tb_l1_refill_engine;

  logic         clk;
  logic         reset;
  logic         miss_req_valid;
  logic         miss_req_ready;
  logic [31:0]  miss_req_addr;
  logic         miss_evict_dirty;
  logic [31:0]  miss_evict_addr;
  logic [127:0] miss_evict_data;
  logic         l2_req_valid;
  logic         l2_req_ready;
  logic         l2_req_write;
  logic [31:0]  l2_req_addr;
  logic [31:0]  l2_wdata;
  logic         l2_rdata_valid;
  logic [31:0]  l2_rdata;
  logic         fill_valid;
  logic         fill_ready;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         busy;

  int vectors;
  int miscompares;

  l1_refill_engine dut (
    .clk              (clk),
    .reset            (reset),
    .miss_req_valid   (miss_req_valid),
    .miss_req_ready   (miss_req_ready),
    .miss_req_addr    (miss_req_addr),
    .miss_evict_dirty (miss_evict_dirty),
    .miss_evict_addr  (miss_evict_addr),
    .miss_evict_data  (miss_evict_data),
    .l2_req_valid     (l2_req_valid),
    .l2_req_ready     (l2_req_ready),
    .l2_req_write     (l2_req_write),
    .l2_req_addr      (l2_req_addr),
    .l2_wdata         (l2_wdata),
    .l2_rdata_valid   (l2_rdata_valid),
    .l2_rdata         (l2_rdata),
    .fill_valid       (fill_valid),
    .fill_ready       (fill_ready),
    .fill_addr        (fill_addr),
    .fill_data        (fill_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Drive four back-to-back read beats base..base+3; fill must not appear early.
  task automatic send_line(input logic [31:0] base, input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_nofill"}, 128'(fill_valid), 128'd0);
      l2_rdata_valid = 1'b1;
      l2_rdata       = base + 32'(i);
      tick();
    end
    l2_rdata_valid = 1'b0;
    l2_rdata       = 32'd0;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    miss_req_valid   = 1'b0;
    miss_req_addr    = 32'd0;
    miss_evict_dirty = 1'b0;
    miss_evict_addr  = 32'd0;
    miss_evict_data  = 128'd0;
    l2_req_ready     = 1'b0;
    l2_rdata_valid   = 1'b0;
    l2_rdata         = 32'd0;
    fill_ready       = 1'b0;

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_ready", 128'(miss_req_ready), 128'd1);
    chk("rst_busy",  128'(busy), 128'd0);
    chk("rst_l2v",   128'(l2_req_valid), 128'd0);
    chk("rst_fillv", 128'(fill_valid), 128'd0);

    // ---- clean miss at 0x1234 ----
    miss_req_valid   = 1'b1;
    miss_req_addr    = 32'h0000_1234;
    miss_evict_dirty = 1'b0;
    miss_evict_addr  = 32'hFFFF_FFF0;
    tick();
    miss_req_valid = 1'b0;
    chk("c_l2v",   128'(l2_req_valid), 128'd1);
    chk("c_l2w",   128'(l2_req_write), 128'd0);
    chk("c_l2a",   128'(l2_req_addr), 128'h1230);
    chk("c_ready", 128'(miss_req_ready), 128'd0);
    chk("c_busy",  128'(busy), 128'd1);
    l2_req_ready = 1'b1;
    tick();
    l2_req_ready = 1'b0;
    chk("c_l2v_off", 128'(l2_req_valid), 128'd0);
    send_line(32'hA000_0000, "c");
    chk("c_fillv", 128'(fill_valid), 128'd1);
    chk("c_filld", fill_data, mk_line(32'hA000_0000));
    chk("c_filla", 128'(fill_addr), 128'h1230);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    chk("c_ready2", 128'(miss_req_ready), 128'd1);
    chk("c_fillv2", 128'(fill_valid), 128'd0);

    // ---- dirty miss, victim 0x8000, stall on write beat 2 ----
    miss_req_valid   = 1'b1;
    miss_req_addr    = 32'h0000_2008;
    miss_evict_dirty = 1'b1;
    miss_evict_addr  = 32'h0000_8000;
    miss_evict_data  = mk_line(32'hD000_0000);
    tick();
    miss_req_valid  = 1'b0;
    miss_evict_data = 128'd0;
    l2_req_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("d_wv", 128'(l2_req_valid), 128'd1);
      chk("d_ww", 128'(l2_req_write), 128'd1);
      chk("d_wa", 128'(l2_req_addr), 128'(32'h8000 + 32'(4 * i)));
      chk("d_wd", 128'(l2_wdata), 128'(32'hD000_0000 + 32'(i)));
      if (i == 2) begin
        l2_req_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("st_wa", 128'(l2_req_addr), 128'h8008);
          chk("st_wd", 128'(l2_wdata), 128'hD000_0002);
          chk("st_wv", 128'(l2_req_valid), 128'd1);
        end
        l2_req_ready = 1'b1;
      end
      tick();
    end
    chk("d_rv", 128'(l2_req_valid), 128'd1);
    chk("d_rw", 128'(l2_req_write), 128'd0);
    chk("d_ra", 128'(l2_req_addr), 128'h2000);
    tick();
    l2_req_ready = 1'b0;
    send_line(32'hB000_0000, "d");
    chk("d_fillv", 128'(fill_valid), 128'd1);
    chk("d_filla", 128'(fill_addr), 128'h2000);

    // ---- fill_ready held low 10 cycles, a new miss waiting meanwhile ----
    miss_req_valid   = 1'b1;
    miss_req_addr    = 32'h0000_3000;
    miss_evict_dirty = 1'b0;
    for (int s = 0; s < 10; s++) begin
      chk("fw_fillv", 128'(fill_valid), 128'd1);
      chk("fw_filld", fill_data, mk_line(32'hB000_0000));
      chk("fw_ready", 128'(miss_req_ready), 128'd0);
      tick();
    end
    fill_ready = 1'b1;
    tick();
    fill_ready     = 1'b0;
    miss_req_valid = 1'b0;
    chk("fw_ready2", 128'(miss_req_ready), 128'd1);
    chk("fw_busy",   128'(busy), 128'd0);
    tick();
    chk("fw_idle", 128'(busy), 128'd0);

    // ---- reset in RD_DATA after two beats, L2 keeps sending ----
    miss_req_valid = 1'b1;
    miss_req_addr  = 32'h0000_4000;
    tick();
    miss_req_valid = 1'b0;
    l2_req_ready   = 1'b1;
    tick();
    l2_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      l2_rdata_valid = 1'b1;
      l2_rdata       = 32'hE000_0000 + 32'(i);
      tick();
    end
    reset    = 1'b1;
    l2_rdata = 32'hE000_0002;
    tick();
    reset    = 1'b0;
    l2_rdata = 32'hE000_0003;
    chk("r_busy",  128'(busy), 128'd0);
    tick();
    l2_rdata_valid = 1'b0;
    l2_rdata       = 32'd0;
    chk("r_busy2",  128'(busy), 128'd0);
    chk("r_ready",  128'(miss_req_ready), 128'd1);
    chk("r_fillv",  128'(fill_valid), 128'd0);
    miss_req_valid = 1'b1;
    miss_req_addr  = 32'h0000_5678;
    tick();
    miss_req_valid = 1'b0;
    chk("r_l2a", 128'(l2_req_addr), 128'h5670);
    l2_req_ready = 1'b1;
    tick();
    l2_req_ready = 1'b0;
    send_line(32'hF000_0000, "r");
    chk("r_fillv2", 128'(fill_valid), 128'd1);
    chk("r_filld",  fill_data, mk_line(32'hF000_0000));
    chk("r_filla",  128'(fill_addr), 128'h5670);
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;

    // ---- stray read beat while IDLE ----
    l2_rdata_valid = 1'b1;
    l2_rdata       = 32'h1111_1111;
    tick();
    l2_rdata_valid = 1'b0;
    tick();
    chk("i_busy",  128'(busy), 128'd0);
    chk("i_fillv", 128'(fill_valid), 128'd0);
    chk("i_ready", 128'(miss_req_ready), 128'd1);
    chk("i_l2v",   128'(l2_req_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
